gtx_link_init: RTL and testbench

Parametrised reset and bring-up sequencer for a bank of N_CH SGMII GTX transceiver channels that share one reference clock and one PLL reset. It replaces the fixed four-flop PMA reset stretcher with a supervised sequence: reset hold, PLL-lock wait with timeout, reset-done wait with timeout, automatic retry, loss-of-lock recovery and per-channel RX elastic-buffer recovery. It sits between the transceiver wrapper and the MAC-side link logic, in the clk_125 domain.

---
 rtl/gtx_link_init.sv | 162 ++++++++++++++++
 tb/tb_gtx_link_init.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/gtx_link_init.sv
// Reset and bring-up sequencer for a bank of SGMII GTX channels sharing one PLL reset.
// It holds reset, waits for PLL lock and for the reset-done flags, retries on a timeout or loss of lock, and pulses per-channel RX buffer resets.
module gtx_link_init #(
  parameter int N_CH           = 1,
  parameter int RST_CYCLES     = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int DONE_TIMEOUT   = 65536,
  parameter int BUF_RST_CYCLES = 4
) (
  input  logic              clk_125,
  input  logic              mgt_reset,
  input  logic [N_CH-1:0]   pll_locked,
  input  logic [N_CH-1:0]   tx_resetdone,
  input  logic [N_CH-1:0]   rx_resetdone,
  input  logic [3*N_CH-1:0] rxbufstatus,
  output logic              gtx_reset,
  output logic              pll_reset,
  output logic [N_CH-1:0]   rxbufreset,
  output logic [N_CH-1:0]   chan_ready,
  output logic              link_ready,
  output logic [7:0]        retry_cnt,
  output logic [2:0]        init_state
);

  localparam int MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_LIM = (MAX_AB > DONE_TIMEOUT) ? MAX_AB : DONE_TIMEOUT;
  localparam int CW      = $clog2(MAX_LIM) + 1;

  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] DONE_LAST = CW'(DONE_TIMEOUT - 1);
  localparam logic [3:0]    BUF_LEN   = 4'(BUF_RST_CYCLES);

  typedef enum logic [2:0] {
    RESET     = 3'd0,
    PLL_WAIT  = 3'd1,
    DONE_WAIT = 3'd2,
    READY     = 3'd3
  } state_t;

  state_t state, state_next;
  logic [CW-1:0] cnt;

  logic [N_CH-1:0] lock_s1, lock_s2, txd_s1, txd_s2, rxd_s1, rxd_s2;
  logic [N_CH-1:0] err_s1, err_s2, err_s3, buf_err, err_rise;
  logic            all_locked, all_done, retry_evt;
  logic            gtx_reset_d, pll_reset_d, link_ready_d;
  logic [N_CH-1:0][3:0] pcnt;
  logic [N_CH-1:0][1:0] rec;

  // Only bit 2 of each status field is used; the other bits are folded into a sink net.
  logic unused_bufstatus;
  assign unused_bufstatus = ^rxbufstatus;

  always_comb begin
    buf_err = '0;
    for (int unsigned i = 0; i < N_CH; i++) buf_err[i] = rxbufstatus[3*i+2];
  end

  always_ff @(posedge clk_125 or posedge mgt_reset) begin
    if (mgt_reset) begin
      lock_s1 <= '0; lock_s2 <= '0;
      txd_s1  <= '0; txd_s2  <= '0;
      rxd_s1  <= '0; rxd_s2  <= '0;
      err_s1  <= '0; err_s2  <= '0; err_s3 <= '0;
    end else begin
      lock_s1 <= pll_locked;   lock_s2 <= lock_s1;
      txd_s1  <= tx_resetdone; txd_s2  <= txd_s1;
      rxd_s1  <= rx_resetdone; rxd_s2  <= rxd_s1;
      err_s1  <= buf_err;      err_s2  <= err_s1;  err_s3 <= err_s2;
    end
  end

  assign all_locked = &lock_s2;
  assign all_done   = (&txd_s2) & (&rxd_s2);
  // A held error would otherwise re-trigger after the recovery window, so only its rising edge starts a pulse.
  assign err_rise   = err_s2 & ~err_s3;

  always_ff @(posedge clk_125 or posedge mgt_reset) begin
    if (mgt_reset) state <= RESET;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      RESET:     if (cnt == RST_LAST) state_next = PLL_WAIT;
      PLL_WAIT:  if (all_locked) state_next = DONE_WAIT;
                 else if (cnt == LOCK_LAST) state_next = RESET;
      DONE_WAIT: if (!all_locked) state_next = RESET;
                 else if (all_done) state_next = READY;
                 else if (cnt == DONE_LAST) state_next = RESET;
      READY:     if (!all_locked) state_next = RESET;
      default:   state_next = RESET;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they move on the same edge as init_state.
  always_comb begin
    gtx_reset_d  = (state_next == RESET) || (state_next == PLL_WAIT);
    pll_reset_d  = (state_next == RESET);
    link_ready_d = (state_next == READY);
  end

  assign retry_evt  = (state != RESET) && (state_next == RESET);
  assign init_state = state;

  always_ff @(posedge clk_125 or posedge mgt_reset) begin
    if (mgt_reset) begin
      gtx_reset  <= 1'b1;
      pll_reset  <= 1'b1;
      link_ready <= 1'b0;
      retry_cnt  <= '0;
      cnt        <= '0;
    end else begin
      gtx_reset  <= gtx_reset_d;
      pll_reset  <= pll_reset_d;
      link_ready <= link_ready_d;
      if (retry_evt && (retry_cnt != 8'hFF)) retry_cnt <= retry_cnt + 8'd1;
      if (state_next != state)  cnt <= '0;
      else if (state != READY)  cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk_125 or posedge mgt_reset) begin
    if (mgt_reset) begin
      pcnt       <= '0;
      rec        <= '0;
      rxbufreset <= '1;
      chan_ready <= '0;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (state_next != READY) begin
          pcnt[i]       <= '0;
          rec[i]        <= '0;
          rxbufreset[i] <= 1'b1;
          chan_ready[i] <= 1'b0;
        end else if (state != READY) begin
          pcnt[i]       <= '0;
          rec[i]        <= '0;
          rxbufreset[i] <= 1'b0;
          chan_ready[i] <= 1'b1;
        end else if (err_rise[i] && (pcnt[i] == '0)) begin
          pcnt[i]       <= BUF_LEN;
          rec[i]        <= '0;
          rxbufreset[i] <= 1'b1;
          chan_ready[i] <= 1'b0;
        end else if (pcnt[i] != '0) begin
          pcnt[i] <= pcnt[i] - 4'd1;
          if (pcnt[i] == 4'd1) begin
            rxbufreset[i] <= 1'b0;
            rec[i]        <= 2'd2;
          end
        end else if (rec[i] != '0) begin
          rec[i] <= rec[i] - 2'd1;
          if (rec[i] == 2'd1) chan_ready[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_gtx_link_init.sv
// Directed bench for gtx_link_init: bring-up, buffer recovery, loss of lock, async reset, done and lock timeouts.
module tb_gtx_link_init;
  localparam int N_CH = 2;
  localparam int RST  = 8;
  localparam int LTO  = 100;
  localparam int DTO  = 100;
  localparam int BUF  = 4;

  logic       clk_125 = 1'b0;
  logic       mgt_reset = 1'b0;
  logic [1:0] pll_locked, tx_resetdone, rx_resetdone;
  logic [5:0] rxbufstatus;
  logic       gtx_reset, pll_reset, link_ready;
  logic [1:0] rxbufreset, chan_ready;
  logic [7:0] retry_cnt;
  logic [2:0] init_state;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  gtx_link_init #(
    .N_CH(N_CH), .RST_CYCLES(RST), .LOCK_TIMEOUT(LTO),
    .DONE_TIMEOUT(DTO), .BUF_RST_CYCLES(BUF)
  ) dut (
    .clk_125(clk_125), .mgt_reset(mgt_reset),
    .pll_locked(pll_locked), .tx_resetdone(tx_resetdone), .rx_resetdone(rx_resetdone),
    .rxbufstatus(rxbufstatus),
    .gtx_reset(gtx_reset), .pll_reset(pll_reset), .rxbufreset(rxbufreset),
    .chan_ready(chan_ready), .link_ready(link_ready), .retry_cnt(retry_cnt),
    .init_state(init_state)
  );

  always #5 clk_125 = ~clk_125;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_125);
      #1;
      cyc++;
    end
  endtask

  task automatic tick_to(input int t);
    while (cyc < t) tick(1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_gtx"},   gtx_reset,  1);
    check({tag, "_pll"},   pll_reset,  1);
    check({tag, "_bufr"},  rxbufreset, 2'b11);
    check({tag, "_chan"},  chan_ready, 2'b00);
    check({tag, "_link"},  link_ready, 0);
    check({tag, "_retry"}, retry_cnt,  0);
    check({tag, "_state"}, init_state, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hi, lo, first, rises, bad0, lr_drop;
    logic prev;

    pll_locked   = '1;
    tx_resetdone = '1;
    rx_resetdone = '1;
    rxbufstatus  = '0;

    #2 mgt_reset = 1'b1;
    tick(3);
    check_reset_vals("rst");

    // nominal bring-up
    mgt_reset = 1'b0;
    cyc = 0;
    tick_to(7);
    check("nom_pll_hold", pll_reset, 1);
    check("nom_gtx_hold", gtx_reset, 1);
    tick_to(8);
    check("nom_pll_fall", pll_reset, 0);
    check("nom_gtx_still", gtx_reset, 1);
    check("nom_state_pll", init_state, 1);
    tick_to(14);
    check("nom_link", link_ready, 1);
    check("nom_chan", chan_ready, 2'b11);
    check("nom_retry", retry_cnt, 0);
    check("nom_state", init_state, 3);
    check("nom_bufr", rxbufreset, 2'b00);

    // buffer error on channel 1 held 10 cycles; low status bits of channel 0 must be ignored
    rxbufstatus = 6'b100_011;
    hi = 0; lo = 0; first = -1; rises = 0; bad0 = 0; lr_drop = 0; prev = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (i == 10) rxbufstatus = '0;
      if (rxbufreset[1]) begin
        hi++;
        if (first < 0) first = i;
        if (!prev) rises++;
      end
      prev = rxbufreset[1];
      if (!chan_ready[1]) lo++;
      if (rxbufreset[0] || !chan_ready[0]) bad0++;
      if (!link_ready) lr_drop++;
    end
    check("buf_latency", first, 3);
    check("buf_pulse_len", hi, BUF);
    check("buf_pulses", rises, 1);
    check("buf_chan_low", lo, BUF + 2);
    check("buf_ch0_clean", bad0, 0);
    check("buf_link_held", lr_drop, 0);
    check("buf_chan_back", chan_ready, 2'b11);

    // one-cycle loss of lock in READY
    pll_locked = 2'b10;
    tick(1);
    pll_locked = '1;
    tick(1);
    check("lol_hold", init_state, 3);
    tick(1);
    check("lol_state", init_state, 0);
    check("lol_gtx", gtx_reset, 1);
    check("lol_bufr", rxbufreset, 2'b11);
    check("lol_retry", retry_cnt, 1);
    check("lol_link", link_ready, 0);
    for (int i = 0; i < 40 && !link_ready; i++) tick(1);
    check("lol_recover", link_ready, 1);
    check("lol_retry_kept", retry_cnt, 1);

    // second loss of lock, then stall in DONE_WAIT and hit it with an async reset
    rx_resetdone = 2'b10;
    pll_locked   = 2'b10;
    tick(1);
    pll_locked = '1;
    tick(2);
    check("dw_state_rst", init_state, 0);
    check("dw_retry", retry_cnt, 2);
    tick(12);
    check("dw_state", init_state, 2);
    check("dw_gtx", gtx_reset, 0);
    check("dw_pll", pll_reset, 0);
    #3 mgt_reset = 1'b1;
    #1;
    check_reset_vals("async");

    // done timeout, then recovery once rx_resetdone[0] rises at cycle 150
    tick(2);
    mgt_reset = 1'b0;
    cyc = 0;
    tick_to(8);
    check("dto_pll", init_state, 1);
    tick_to(9);
    check("dto_dw", init_state, 2);
    tick_to(108);
    check("dto_before", init_state, 2);
    check("dto_retry0", retry_cnt, 0);
    tick_to(109);
    check("dto_fire", init_state, 0);
    check("dto_retry1", retry_cnt, 1);
    tick_to(118);
    check("dto_dw2", init_state, 2);
    tick_to(150);
    rx_resetdone = '1;
    tick_to(152);
    check("dto_wait_sync", init_state, 2);
    tick_to(153);
    check("dto_ready", init_state, 3);
    check("dto_link", link_ready, 1);
    check("dto_retry_end", retry_cnt, 1);

    // lock timeout with pll_locked[1] stuck low: one retry every 108 cycles, saturating at 255
    mgt_reset  = 1'b1;
    pll_locked = 2'b01;
    tick(2);
    mgt_reset = 1'b0;
    cyc = 0;
    tick_to(107);
    check("lto_wait", init_state, 1);
    check("lto_retry0", retry_cnt, 0);
    tick_to(108);
    check("lto_fire", init_state, 0);
    check("lto_retry1", retry_cnt, 1);
    tick_to(215);
    check("lto_retry1_hold", retry_cnt, 1);
    tick_to(216);
    check("lto_retry2", retry_cnt, 2);
    tick_to(255 * 108 - 1);
    check("lto_retry254", retry_cnt, 254);
    tick_to(255 * 108);
    check("lto_retry255", retry_cnt, 255);
    tick_to(300 * 108);
    check("lto_sat", retry_cnt, 255);
    check("lto_link", link_ready, 0);
    check("lto_state", init_state, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
